// File: rtl/fifo_rd_ctrl_if.sv
// Handshake bundle between fifo_rd_ctrl, its upstream FIFO and the downstream consumer.
// The master modport is the controller's view.
interface fifo_rd_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
);
  logic                  fifoEmpty;
  logic                  fifoAlmostEmpty;
  logic [DATA_WIDTH-1:0] fifoData;
  logic                  sRead;
  logic                  outValid;
  logic                  outReady;
  logic [DATA_WIDTH-1:0] outData;
  logic [CNT_WIDTH-1:0]  wordCount;
  logic                  errorOverrun;

  modport master (
    input  fifoEmpty, fifoAlmostEmpty, fifoData, outReady,
    output sRead, outValid, outData, wordCount, errorOverrun
  );

  modport slave (
    output fifoEmpty, fifoAlmostEmpty, fifoData, outReady,
    input  sRead, outValid, outData, wordCount, errorOverrun
  );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read controller: pulls words from an upstream FIFO into a 2-entry skid buffer
// and presents them downstream with valid/ready, counting delivered words.
module fifo_rd_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ENB,
  input  logic          drain,
  fifo_rd_ctrl_if.master bus
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    READ = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic                  rd_pending_q, rd_pending_d;
  logic [1:0]            occ_q, occ_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic                  overrun_q, overrun_d;

  logic                  pop_s;
  logic                  rd_s;
  logic [2:0]            occ_proj_s;
  logic [1:0]            occ_mid_s;

  // Read strobe: only issue a read if the word it returns is guaranteed a slot.
  always_comb begin
    pop_s      = (occ_q != 2'd0) && bus.outReady;
    occ_proj_s = {1'b0, occ_q} + {2'b00, rd_pending_q} - {2'b00, pop_s};
    rd_s       = (state_q == READ) && ENB && !bus.fifoEmpty && (occ_proj_s < 3'd2);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (ENB && !bus.fifoEmpty && (!bus.fifoAlmostEmpty || drain)) begin
          state_d = READ;
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (!ENB || (bus.fifoEmpty && !rd_s)) begin
          state_d = IDLE;
        end else begin
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Skid buffer: pop shifts first, then the returning word lands in the first free slot.
  always_comb begin
    occ_mid_s    = occ_q - {1'b0, pop_s};
    occ_d        = occ_mid_s;
    buf1_d       = buf1_q;
    overrun_d    = overrun_q;
    rd_pending_d = rd_s;
    if (pop_s) begin
      buf0_d = buf1_q;
    end else begin
      buf0_d = buf0_q;
    end
    if (rd_pending_q) begin
      case (occ_mid_s)
        2'd0: begin
          buf0_d = bus.fifoData;
          occ_d  = 2'd1;
        end
        2'd1: begin
          buf1_d = bus.fifoData;
          occ_d  = 2'd2;
        end
        default: overrun_d = 1'b1;
      endcase
    end else begin
      occ_d = occ_mid_s;
    end
    count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, pop_s};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      rd_pending_q <= 1'b0;
      occ_q        <= 2'd0;
      buf0_q       <= {DATA_WIDTH{1'b0}};
      buf1_q       <= {DATA_WIDTH{1'b0}};
      count_q      <= {CNT_WIDTH{1'b0}};
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_pending_q <= rd_pending_d;
      occ_q        <= occ_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      count_q      <= count_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.sRead        = rd_s;
  assign bus.outValid     = (occ_q != 2'd0);
  assign bus.outData      = buf0_q;
  assign bus.wordCount    = count_q;
  assign bus.errorOverrun = overrun_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Scoreboard bench for fifo_rd_ctrl: every word written to the modelled upstream FIFO
// must come out downstream in order, exactly once, with wordCount tracking deliveries.
module tb_fifo_rd_ctrl;

  logic CLK;
  logic RST;
  logic ENB;
  logic drain;

  fifo_rd_ctrl_if #(.DATA_WIDTH(8), .CNT_WIDTH(16)) bus_if ();

  fifo_rd_ctrl #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .ENB  (ENB),
    .drain(drain),
    .bus  (bus_if.master)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] up_q[$];
  logic [7:0] exp_q[$];

  logic       rd_prev = 1'b0;
  logic       stall_prev = 1'b0;
  logic [7:0] stall_data = 8'h00;
  int         pops_seen = 0;
  int         sread_cnt = 0;
  int         cur_rd = 0;
  int         max_rd_run = 0;
  int         cur_pop = 0;
  int         max_pop_run = 0;
  int         rst_epoch = 0;
  int         seen_epoch = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w);
    up_q.push_back(w);
    exp_q.push_back(w);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_drain(input int budget, input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || up_q.size() != 0) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    check(name, exp_q.size(), 0);
    cyc(2);
  endtask

  // Upstream FIFO: a read strobe seen in one cycle returns the head word in the next.
  always @(posedge CLK) begin
    #1;
    if (rd_prev && up_q.size() > 0) bus_if.fifoData = up_q.pop_front();
    bus_if.fifoEmpty       = (up_q.size() == 0);
    bus_if.fifoAlmostEmpty = (up_q.size() <= 2);
  end

  // Monitor: compares every delivered word against the scoreboard and checks handshake rules.
  always @(negedge CLK) begin
    if (!RST) begin
      rd_prev    = 1'b0;
      stall_prev = 1'b0;
    end else begin
      if (rst_epoch != seen_epoch) begin
        seen_epoch = rst_epoch;
        pops_seen  = 0;
        stall_prev = 1'b0;
        cur_rd     = 0;
        cur_pop    = 0;
      end
      check("word_count", {16'h0000, bus_if.wordCount}, {16'h0000, pops_seen[15:0]});
      check("no_overrun", bus_if.errorOverrun, 1'b0);
      if (stall_prev) begin
        check("hold_valid", bus_if.outValid, 1'b1);
        check("hold_data", bus_if.outData, stall_data);
      end
      if (bus_if.sRead) check("read_nonempty", bus_if.fifoEmpty, 1'b0);
      if (bus_if.outValid && bus_if.outReady) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word_pending", 32'd0, 32'd1);
        end else begin
          check("out_data", bus_if.outData, exp_q.pop_front());
        end
        pops_seen++;
        cur_pop++;
        if (cur_pop > max_pop_run) max_pop_run = cur_pop;
      end else begin
        cur_pop = 0;
      end
      if (bus_if.sRead) begin
        sread_cnt++;
        cur_rd++;
        if (cur_rd > max_rd_run) max_rd_run = cur_rd;
      end else begin
        cur_rd = 0;
      end
      stall_prev = bus_if.outValid && !bus_if.outReady;
      stall_data = bus_if.outData;
      rd_prev    = bus_if.sRead;
    end
  end

  initial begin
    int  base;
    int  n;
    bit  found;

    RST = 1'b0;
    ENB = 1'b0;
    drain = 1'b0;
    bus_if.outReady = 1'b0;
    bus_if.fifoEmpty = 1'b1;
    bus_if.fifoAlmostEmpty = 1'b1;
    bus_if.fifoData = 8'h00;
    #3;
    check("rst_outValid", bus_if.outValid, 1'b0);
    check("rst_sRead", bus_if.sRead, 1'b0);
    check("rst_outData", bus_if.outData, 8'h00);
    check("rst_wordCount", bus_if.wordCount, 16'h0000);
    check("rst_errorOverrun", bus_if.errorOverrun, 1'b0);
    cyc(2);
    RST = 1'b1;
    ENB = 1'b1;
    bus_if.outReady = 1'b1;
    cyc(2);

    // Streaming: eight words at full rate
    for (int i = 0; i < 8; i++) push(i[7:0]);
    wait_drain(100, "stream_drain");
    check("stream_sread_run", max_rd_run, 8);
    check("stream_pop_run", max_pop_run, 8);
    check("stream_count", bus_if.wordCount, 16'd8);

    // Threshold: two words sit below almost-empty until drain
    base = sread_cnt;
    push(8'hA1);
    push(8'hA2);
    cyc(6);
    check("thresh_no_read", sread_cnt, base);
    drain = 1'b1;
    @(posedge CLK);
    #2;
    check("drain_enter_read", bus_if.sRead, 1'b1);
    wait_drain(50, "thresh_drain");
    check("thresh_count", bus_if.wordCount, 16'd10);
    drain = 1'b0;

    // Backpressure: reads stop once the skid buffer is committed
    bus_if.outReady = 1'b0;
    base = sread_cnt;
    for (int i = 0; i < 6; i++) push(8'h30 + i[7:0]);
    cyc(10);
    check("bp_two_reads", sread_cnt, base + 2);
    check("bp_valid", bus_if.outValid, 1'b1);
    check("bp_head", bus_if.outData, 8'h30);
    bus_if.outReady = 1'b1;
    wait_drain(100, "bp_drain");
    check("bp_overrun", bus_if.errorOverrun, 1'b0);

    // ENB drop right after the first read: in-flight word still lands
    for (int i = 0; i < 6; i++) push(8'h50 + i[7:0]);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(posedge CLK);
      #2;
      if (bus_if.sRead) found = 1'b1;
    end
    check("enb_first_read_seen", found, 1'b1);
    base = sread_cnt;
    @(posedge CLK);
    #1;
    ENB = 1'b0;
    bus_if.outReady = 1'b0;
    cyc(4);
    check("enb_one_read", sread_cnt, base + 1);
    check("enb_valid", bus_if.outValid, 1'b1);
    check("enb_word", bus_if.outData, 8'h50);
    ENB = 1'b1;
    bus_if.outReady = 1'b1;
    wait_drain(100, "enb_drain");

    // Reset with a full skid buffer: buffered words are discarded, FIFO contents survive
    bus_if.outReady = 1'b0;
    for (int i = 0; i < 6; i++) push(8'h70 + i[7:0]);
    cyc(8);
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    check("mid_rst_outValid", bus_if.outValid, 1'b0);
    check("mid_rst_sRead", bus_if.sRead, 1'b0);
    check("mid_rst_wordCount", bus_if.wordCount, 16'h0000);
    check("mid_rst_outData", bus_if.outData, 8'h00);
    check("mid_rst_overrun", bus_if.errorOverrun, 1'b0);
    exp_q = up_q;
    rst_epoch++;
    RST = 1'b1;
    #1;
    check("sread_after_rst", bus_if.sRead, 1'b0);
    cyc(1);
    bus_if.outReady = 1'b1;
    wait_drain(100, "rst_drain");
    check("rst_remaining_count", bus_if.wordCount, 16'd4);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      cyc(1);
      if (up_q.size() < 12 && $urandom_range(0, 2) == 0) push($urandom_range(0, 255));
      bus_if.outReady = ($urandom_range(0, 3) != 0);
      drain = ($urandom_range(0, 7) == 0);
      ENB = ($urandom_range(0, 15) != 0);
    end
    ENB = 1'b1;
    drain = 1'b1;
    bus_if.outReady = 1'b1;
    wait_drain(300, "rand_drain");

    // Counter wrap at 0xFFFF
    n = 65535 - pops_seen;
    for (int i = 0; i < n; i++) push(i[7:0]);
    wait_drain(70000, "wrap_fill_drain");
    check("wrap_max", bus_if.wordCount, 16'hFFFF);
    push(8'hEE);
    wait_drain(50, "wrap_last_drain");
    check("wrap_zero", bus_if.wordCount, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
